// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Performs WIDTH-bit additions on one shared 4-bit adder slice, one nibble
//   per clock, least-significant nibble first, with the carry registered
//   between nibbles. Handshake: start (sampled when not computing) /
//   busy / done (single-cycle pulse).
//
//   Optional feature macro: NSA_SUB_EN
//     defined   -> adds the 'sub' port; sub=1 computes a - b as a + ~b + 1
//                  (c_in ignored, c_out=1 means no borrow)
//     undefined -> no 'sub' port, add only
//
//   The DONE cycle also samples start. This lets a requester that holds
//   start high get back-to-back operations every NIB+1 cycles. A start pulse
//   that ends before the DONE cycle is never remembered.

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef NSA_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic               r_cy;
  logic [WIDTH-1:0]   r_a;     // operand A, shifted down one nibble per step
  logic [WIDTH-1:0]   r_b;     // operand B (already inverted for subtract)
  logic [WIDTH-1:0]   r_acc;   // partial result, nibbles enter from the top
  logic [WIDTH-1:0]   r_sum;
  logic               r_c_out;
  logic               r_busy;
  logic               r_done;

  logic [WIDTH-1:0]   w_b_in;
  logic               w_cy_in;
  logic [4:0]         w_nib;
  logic [WIDTH-1:0]   w_acc_next;

  // Operand B and the nibble-0 carry as they are captured at accept time.
  // Subtraction is folded in here, so the datapath itself only ever adds.
`ifdef NSA_SUB_EN
  assign w_b_in  = sub ? ~b : b;
  assign w_cy_in = sub ? 1'b1 : c_in;
`else
  assign w_b_in  = b;
  assign w_cy_in = c_in;
`endif

  // The shared 4-bit slice. The low nibbles of the shifting operand
  // registers always hold the nibble currently being processed.
  assign w_nib      = {1'b0, r_a[3:0]} + {1'b0, r_b[3:0]} + {4'b0000, r_cy};
  assign w_acc_next = {w_nib[3:0], r_acc[WIDTH-1:4]};

  // Sequencer: accept, step one nibble per clock, publish, pulse done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: operand and accumulator registers are reset too, so a reset
      // in the middle of an operation leaves no stale data behind.
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cy    <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_c_out <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      // NOTE: non-blocking default. The RUN branch below can override it in
      // the same cycle, and the last assignment wins.
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= w_b_in;
            r_cy    <= w_cy_in;
            r_acc   <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        S_RUN: begin
          r_a   <= r_a >> 4;
          r_b   <= r_b >> 4;
          r_cy  <= w_nib[4];
          r_acc <= w_acc_next;
          if (r_idx == IDX_LAST) begin
            // Only the finished result is ever made visible.
            r_sum   <= w_acc_next;
            r_c_out <= w_nib[4];
            r_done  <= 1'b1;
            r_idx   <= '0;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign sum   = r_sum;
  assign c_out = r_c_out;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Testbench for nibble_serial_adder (WIDTH=16).
// A table of vectors plus random operands go through a scoreboard queue.
// Hand-written sequences cover back-to-back start, operand changes during
// RUN, and a reset in the middle of an operation. When NSA_SUB_EN is
// defined, subtract vectors are added as well.

module tb_nibble_serial_adder;

  localparam int W = 16;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         c_in  = 1'b0;
  logic         sub   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;

  int total  = 0;
  int bad    = 0;
  int n_done = 0;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         sb;
    logic [W-1:0] es;
    logic         ec;
  } vec_t;

  res_t q[$];
  res_t mon_r;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
`ifdef NSA_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: each done pulse pops one expected result.
  always @(negedge clk) begin
    if (rst_n && done === 1'b1) begin
      n_done++;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no pending result at %0t", $time);
      end else begin
        mon_r = q.pop_front();
        check("sum", {16'h0, sum}, {16'h0, mon_r.s});
        check("c_out", {31'h0, c_out}, {31'h0, mon_r.c});
      end
    end
  end

  task automatic wait_idle();
    int cnt = 0;
    while (busy !== 1'b0 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("idle_timeout", {31'h0, busy}, 32'h0);
  endtask

  // One isolated operation: latency, pulse width and busy are checked here.
  // The result itself is checked by the scoreboard.
  task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                        input logic ci, input logic sbi,
                        input logic [W-1:0] es, input logic ec);
    int cnt;
    wait_idle();
    @(posedge clk); #1;
    a = ai; b = bi; c_in = ci; sub = sbi; start = 1'b1;
    @(posedge clk); #1;                       // E0 accepted
    start = 1'b0;
    q.push_back('{es, ec});
    check("busy_after_start", {31'h0, busy}, 32'h1);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (done !== 1'b1 && cnt < 20);
    check("latency", cnt - 1, 32'd4);
    @(negedge clk);
    check("done_width", {31'h0, done}, 32'h0);
    check("busy_end", {31'h0, busy}, 32'h0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t         vt[7];
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W:0]   m;
    int           n0;

    vt[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0};
    vt[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1};
    vt[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1};
    vt[3] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1};
    vt[4] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0};
    vt[5] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0};
    vt[6] = '{16'hABCD, 16'h1111, 1'b1, 1'b0, 16'hBCDF, 1'b0};

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_sum", {16'h0, sum}, 32'h0);
    check("rst_c_out", {31'h0, c_out}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    rst_n = 1'b1;

    // Table vectors.
    for (int i = 0; i < 7; i++)
      run_op(vt[i].a, vt[i].b, vt[i].ci, vt[i].sb, vt[i].es, vt[i].ec);

    // Random operands against a 17-bit reference sum.
    for (int i = 0; i < 6; i++) begin
      ra = W'($urandom_range(0, 65535));
      rb = W'($urandom_range(0, 65535));
      rc = 1'($urandom_range(0, 1));
      m  = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      run_op(ra, rb, rc, 1'b0, m[W-1:0], m[W]);
    end

`ifdef NSA_SUB_EN
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
    run_op(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1);
    run_op(16'h0007, 16'h0005, 1'b1, 1'b0, 16'h000D, 1'b0);
`endif

    // Start pulsed and operands changed during RUN: latched operands only,
    // and a single done pulse.
    wait_idle();
    @(posedge clk); #1;
    a = 16'h1234; b = 16'h1111; c_in = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;                       // E0
    start = 1'b0;
    q.push_back('{16'h2345, 1'b0});
    n0 = n_done;
    @(posedge clk); #1;                       // cycle 1
    start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b1;
    @(posedge clk); #1;                       // cycle 2
    start = 1'b0; a = 16'h0000; b = 16'h0000;
    repeat (8) @(negedge clk);
    check("midrun_done_count", n_done - n0, 32'd1);
    check("midrun_busy_end", {31'h0, busy}, 32'h0);

    // Start held high: busy through cycles 0-4, second accept at E5,
    // second done at cycle 9.
    @(posedge clk); #1;
    a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;                       // E0
    q.push_back('{16'hFFFF, 1'b1});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("held_busy", {31'h0, busy}, 32'h1);
      check("held_done", {31'h0, done}, {31'h0, (i == 4 || i == 9)});
      if (i == 5) begin
        start = 1'b0;
        q.push_back('{16'hFFFF, 1'b1});
      end
    end
    @(negedge clk);
    check("held_busy_end", {31'h0, busy}, 32'h0);

    // Reset asserted at E2 of an operation: everything cleared, no done.
    @(posedge clk); #1;
    a = 16'h1234; b = 16'h4321; c_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;                       // E0
    start = 1'b0;
    n0 = n_done;
    @(posedge clk);                           // E1
    @(posedge clk); #1;                       // E2
    rst_n = 1'b0;
    #1;
    check("mid_rst_sum", {16'h0, sum}, 32'h0);
    check("mid_rst_c_out", {31'h0, c_out}, 32'h0);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check("mid_rst_done", {31'h0, done}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("mid_rst_no_done", n_done - n0, 32'd0);
    check("mid_rst_queue", q.size(), 32'd0);
    check("mid_rst_busy_after", {31'h0, busy}, 32'h0);

    // Normal operation resumes after the reset.
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0);
    repeat (2) @(negedge clk);
    check("final_queue_empty", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
